// File: rtl/pipelined_cla_adder.sv
// Two-stage carry-lookahead adder/subtractor with valid/ready handshake on both sides.
// Latency: 2 cycles from accept to out_valid when unstalled; 1 result per cycle sustained.
// Backpressure: out_ready low holds stage 2; stage 1 refills only when stage 2 empties or drains.
// Optional CLA_FLAGS_EN macro adds registered zero/neg/ovf status outputs.
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_FLAGS_EN
    ,
    output logic             zero,
    output logic             neg,
    output logic             ovf
`endif
);

    localparam int NG = WIDTH / 4;

    // Reject unsupported configurations at elaboration time.
    if (GROUP != 4) begin : g_bad_group
        $error("pipelined_cla_adder: GROUP must be 4");
    end
    if ((WIDTH % 4) != 0 || WIDTH < 8 || WIDTH > 64) begin : g_bad_width
        $error("pipelined_cla_adder: WIDTH must be a multiple of 4 in 8..64");
    end

    // Stage 1 state: per-bit propagate/generate, per-group G/P, effective carry-in.
    logic             s1_valid;
    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_g;
    logic [NG-1:0]    s1_gg;
    logic [NG-1:0]    s1_pg;
    logic             s1_cin;

    // Stage 2 state.
    logic             s2_valid;

    // Handshake: stage 2 can take new data when empty or draining this cycle.
    logic s2_en;
    logic accept;

    assign s2_en     = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || !s2_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_valid;

    // Stage 1 combinational: operand conditioning and first-level lookahead.
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] g_in;
    logic             cin_eff;
    logic [NG-1:0]    gg_in;
    logic [NG-1:0]    pg_in;

    // Build per-bit p/g and per-group G/P from the (possibly inverted) operands.
    always_comb begin
        b_eff   = b ^ {WIDTH{sub}};
        p_in    = a ^ b_eff;
        g_in    = a & b_eff;
        cin_eff = sub | cin;
        gg_in   = '0;
        pg_in   = '0;
        for (int k = 0; k < NG; k++) begin
            gg_in[k] = g_in[4*k+3]
                     | (p_in[4*k+3] & g_in[4*k+2])
                     | (p_in[4*k+3] & p_in[4*k+2] & g_in[4*k+1])
                     | (p_in[4*k+3] & p_in[4*k+2] & p_in[4*k+1] & g_in[4*k]);
            pg_in[k] = &p_in[4*k +: 4];
        end
    end

    // Stage 1 register: load on accept, otherwise empty out when stage 2 takes the entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_gg    <= '0;
            s1_pg    <= '0;
            s1_cin   <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_p     <= p_in;
                s1_g     <= g_in;
                s1_gg    <= gg_in;
                s1_pg    <= pg_in;
                s1_cin   <= cin_eff;
            end else if (s2_en) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2 combinational: second-level lookahead, in-group carries, sum.
    logic [NG:0]      c_grp;
    logic [WIDTH-1:0] c_bit;
    logic [WIDTH-1:0] sum_nxt;
    logic             cout_nxt;
    logic [NG-1:0]    g_top_unused;

    // Group carries are flat sums of products over G/P; bit carries ripple inside a group.
    always_comb begin
        logic acc;
        logic prod;
        acc          = 1'b0;
        prod         = 1'b1;
        c_grp        = '0;
        c_bit        = '0;
        g_top_unused = '0;
        c_grp[0]     = s1_cin;
        for (int k = 0; k < NG; k++) begin
            acc  = 1'b0;
            prod = 1'b1;
            for (int j = k; j >= 0; j--) begin
                acc  = acc | (prod & s1_gg[j]);
                prod = prod & s1_pg[j];
            end
            c_grp[k+1] = acc | (prod & s1_cin);
        end
        for (int k = 0; k < NG; k++) begin
            c_bit[4*k] = c_grp[k];
            for (int i = 1; i < 4; i++) begin
                c_bit[4*k+i] = s1_g[4*k+i-1] | (s1_p[4*k+i-1] & c_bit[4*k+i-1]);
            end
            // Top-of-group generate is already folded into G.
            g_top_unused[k] = s1_g[4*k+3];
        end
        sum_nxt  = s1_p ^ c_bit;
        cout_nxt = c_grp[NG];
    end

`ifdef CLA_FLAGS_EN
    // Flags: p==0 at the MSB means both operand MSBs agree, and then g equals that MSB.
    logic zero_nxt;
    logic neg_nxt;
    logic ovf_nxt;

    assign zero_nxt = (sum_nxt == '0);
    assign neg_nxt  = sum_nxt[WIDTH-1];
    assign ovf_nxt  = !s1_p[WIDTH-1] && (s1_g[WIDTH-1] != sum_nxt[WIDTH-1]);
`endif

    // Stage 2 register: advance when empty or draining; hold everything while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
`ifdef CLA_FLAGS_EN
            zero     <= 1'b0;
            neg      <= 1'b0;
            ovf      <= 1'b0;
`endif
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                sum  <= sum_nxt;
                cout <= cout_nxt;
`ifdef CLA_FLAGS_EN
                zero <= zero_nxt;
                neg  <= neg_nxt;
                ovf  <= ovf_nxt;
`endif
            end
        end
    end

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; legal values are multiples of 4 from 8 to 64.
REQ-002 SHALL have parameter GROUP, default 4, bits per lookahead group; fixed at 4, and other values are rejected at elaboration.
REQ-003 SHALL have port clk  input  1  single clock, rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operands present.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port sub  input  1  0 gives A+B+cin; 1 gives A-B (B inverted, carry-in forced to 1).
REQ-010 SHALL have port cin  input  1  carry-in; ignored when sub=1.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-013 SHALL have port sum  output  WIDTH  result.
REQ-014 SHALL have port cout  output  1  carry out of the MSB; for sub=1, 1 means no borrow.

Function
REQ-015 SHALL transfer input when in_valid&&in_ready and output when out_valid&&out_ready.
REQ-016 SHALL compute in stage 1: per-bit p=a^b', g=a&b' (b'=b^{WIDTH{sub}}), plus per-group G=g3|p3g2|p3p2g1|p3p2p1g0 and P=p3p2p1p0, all registered with the operands' p, g and effective cin.
REQ-017 SHALL compute in stage 2: inter-group carries by second-level lookahead over G/P, in-group carries, sum=p^c and cout; sum and cout are registered.
REQ-018 SHALL have a fixed latency of 2 cycles from accepted input to out_valid with no stalls, and sustain 1 result per cycle when out_ready is held high.
REQ-019 SHALL drive in_ready = !s1_valid || !s2_valid || out_ready, so stage 1 advances only when stage 2 empties or drains in the same cycle.
REQ-020 SHALL hold sum, cout and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL, on simultaneous accept and drain with both stages full, shift stage 1 into stage 2 and load new operands into stage 1 with no bubble.
REQ-022 SHALL produce results identical to ({1'b0,a}+{1'b0,b'}+cin_eff) truncated to WIDTH+1 bits, for every WIDTH.
REQ-023 SHALL keep result ordering strictly FIFO, with no drop and no duplication.

Reset
REQ-024 SHALL, while reset is high, asynchronously clear both stage valid bits, sum, cout and all stage registers to 0.
REQ-025 SHALL drive in_ready=1 and out_valid=0 during reset and in the first cycle after it.
REQ-026 SHALL discard all in-flight operations on mid-operation reset, with no result emitted for them afterwards.

Configuration
REQ-027 SHALL, when macro CLA_FLAGS_EN is defined, add outputs zero (sum==0), neg (sum[WIDTH-1]) and ovf (signed overflow: operand MSBs equal after inversion and differing from the sum MSB), each 1 bit, registered with sum and reset to 0.
REQ-028 SHALL omit the zero, neg and ovf ports and their logic when CLA_FLAGS_EN is undefined; sum/cout behaviour is unchanged.

Verification
REQ-029 SHALL cover, at WIDTH=16: a=16'hFFFF, b=16'h0001, sub=0, cin=0 -> sum=16'h0000, cout=1 two cycles later; zero=1, ovf=0 when flags enabled.
REQ-030 SHALL cover: a=16'h7FFF, b=16'h0001, sub=0 -> sum=16'h8000, cout=0, ovf=1, neg=1.
REQ-031 SHALL cover: a=16'h0005, b=16'h0007, sub=1 -> sum=16'hFFFE, cout=0 (borrow), neg=1.
REQ-032 SHALL cover: back-to-back inputs 1+1, 2+2, 3+3 with out_ready=1 -> sums 2, 4, 6 on consecutive cycles starting 2 cycles after the first accept.
REQ-033 SHALL cover: out_ready=0 for 5 cycles with 3 inputs offered -> in_ready falls after 2 accepts, sum stays stable, then 3 results drain in order after out_ready=1.
REQ-034 SHALL cover: reset asserted 1 cycle after an accept -> out_valid stays 0 and the next accepted operation returns the correct result at latency 2; a random sweep at WIDTH=8/32/64 matches the reference model.
